// File: rtl/pulse_stretcher.sv
// -----------------------------------------------------------------------------
// pulse_stretcher
//   Converts single-cycle event strobes into level pulses. Each pulse is high for
//   HOLD_CYCLES cycles and is followed by a forced-low gap of GAP_CYCLES cycles.
//   Events that arrive while a pulse or gap is in progress are counted in a
//   saturating pending counter. Each counted event is replayed later as its own
//   pulse.
//
// Optional feature macro: PULSE_STRETCHER_EDGE_IN_EN
//   Defined   : only a rising edge of pulse_in counts as an event, so pulse_in
//               may be a level or a button signal.
//   Undefined : every cycle with pulse_in high counts as one event.
//
// Ports
//   clk        in   system clock, all logic on the rising edge
//   rst        in   synchronous, active-high reset
//   pulse_in   in   event strobe (or level input when edge mode is enabled)
//   level_out  out  stretched pulse, registered
//   busy       out  high whenever the state is not IDLE, registered
//   pending    out  [PEND_W] events queued but not yet shown
//   overflow   out  sticky flag: an event was dropped at saturation
// -----------------------------------------------------------------------------
module pulse_stretcher #(
   parameter int HOLD_CYCLES = 4,
   parameter int GAP_CYCLES  = 2,
   parameter int PEND_W      = 2
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              pulse_in,
   output logic              level_out,
   output logic              busy,
   output logic [PEND_W-1:0] pending,
   output logic              overflow
);

   localparam int MAX_HG = (HOLD_CYCLES > GAP_CYCLES) ? HOLD_CYCLES : GAP_CYCLES;
   localparam int TW     = (MAX_HG > 1) ? $clog2(MAX_HG) : 1;

   localparam logic [TW-1:0]     HOLD_LOAD = TW'(HOLD_CYCLES - 1);
   localparam logic [TW-1:0]     GAP_LOAD  = TW'(GAP_CYCLES - 1);
   localparam logic [TW-1:0]     TIMER_ONE = TW'(1);
   localparam logic [TW-1:0]     TIMER_ZERO = TW'(0);
   localparam logic [PEND_W-1:0] PEND_MAX  = {PEND_W{1'b1}};
   localparam logic [PEND_W-1:0] PEND_ONE  = PEND_W'(1);
   localparam logic [PEND_W-1:0] PEND_ZERO = PEND_W'(0);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      HOLD = 2'd1,
      GAP  = 2'd2
   } state_t;

   state_t            r_state;
   state_t            w_state_nxt;
   logic [TW-1:0]     r_timer;
   logic [TW-1:0]     w_timer_nxt;
   logic [PEND_W-1:0] r_pending;
   logic [PEND_W-1:0] w_pending_nxt;
   logic              r_overflow;
   logic              w_overflow_nxt;
   logic              r_level;
   logic              r_busy;
   logic              w_event;
   logic              w_last_gap;
   logic              w_enq;
   logic              w_deq;

`ifdef PULSE_STRETCHER_EDGE_IN_EN
   logic              r_prev;

   // Previous-cycle copy of pulse_in, used for rising-edge detection.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_prev <= 1'b0;
      end else begin
         r_prev <= pulse_in;
      end
   end

   // The event is recognised in the same cycle the input first reads high.
   assign w_event = pulse_in & ~r_prev;
`else
   assign w_event = pulse_in;
`endif

   assign w_last_gap = (r_state == GAP) && (r_timer == TIMER_ZERO);

   // Next-state, timer and pending-counter logic.
   always_comb begin
      w_state_nxt    = r_state;
      w_timer_nxt    = r_timer;
      w_pending_nxt  = r_pending;
      w_overflow_nxt = r_overflow;

      // An event in the last gap cycle with work already queued is treated as
      // a simultaneous enqueue and dequeue, so pending stays the same.
      w_deq = w_last_gap && (r_pending != PEND_ZERO);
      w_enq = w_event && ((r_state == HOLD) ||
                          ((r_state == GAP) && (r_timer != TIMER_ZERO)) ||
                          w_deq);

      case (r_state)
         IDLE: begin
            if (w_event) begin
               w_state_nxt = HOLD;
               w_timer_nxt = HOLD_LOAD;
            end else begin
               w_state_nxt = IDLE;
               w_timer_nxt = TIMER_ZERO;
            end
         end
         HOLD: begin
            if (r_timer == TIMER_ZERO) begin
               w_state_nxt = GAP;
               w_timer_nxt = GAP_LOAD;
            end else begin
               w_timer_nxt = r_timer - TIMER_ONE;
            end
         end
         GAP: begin
            if (r_timer == TIMER_ZERO) begin
               if ((r_pending != PEND_ZERO) || w_event) begin
                  w_state_nxt = HOLD;
                  w_timer_nxt = HOLD_LOAD;
               end else begin
                  w_state_nxt = IDLE;
                  w_timer_nxt = TIMER_ZERO;
               end
            end else begin
               w_timer_nxt = r_timer - TIMER_ONE;
            end
         end
         default: begin
            w_state_nxt = IDLE;
            w_timer_nxt = TIMER_ZERO;
         end
      endcase

      if (w_enq && !w_deq) begin
         if (r_pending == PEND_MAX) begin
            w_overflow_nxt = 1'b1;
         end else begin
            w_pending_nxt = r_pending + PEND_ONE;
         end
      end else if (w_deq && !w_enq) begin
         w_pending_nxt = r_pending - PEND_ONE;
      end else begin
         w_pending_nxt = r_pending;
      end
   end

   // State, counters and registered outputs. Reset truncates any pulse in flight.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state    <= IDLE;
         r_timer    <= TIMER_ZERO;
         r_pending  <= PEND_ZERO;
         r_overflow <= 1'b0;
         r_level    <= 1'b0;
         r_busy     <= 1'b0;
      end else begin
         r_state    <= w_state_nxt;
         r_timer    <= w_timer_nxt;
         r_pending  <= w_pending_nxt;
         r_overflow <= w_overflow_nxt;
         r_level    <= (w_state_nxt == HOLD);
         r_busy     <= (w_state_nxt != IDLE);
      end
   end

   assign level_out = r_level;
   assign busy      = r_busy;
   assign pending   = r_pending;
   assign overflow  = r_overflow;

endmodule

// File: tb/tb_pulse_stretcher.sv
// -----------------------------------------------------------------------------
// tb_pulse_stretcher
//   Directed bench for pulse_stretcher with default parameters. In each cycle
//   the bench drives rst/pulse_in and pushes the outputs it expects after that
//   edge into a scoreboard queue. After the edge it pops the entry and compares.
//   Cycle c means that inputs are driven for edge c and outputs are observed in
//   cycle c+1.
// -----------------------------------------------------------------------------
module tb_pulse_stretcher;

   typedef struct packed {
      logic       l;
      logic       b;
      logic [1:0] p;
      logic       o;
   } exp_t;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       pulse_in = 1'b0;
   logic       level_out;
   logic       busy;
   logic [1:0] pending;
   logic       overflow;

   exp_t exp_q[$];
   int   n_assert = 0;
   int   n_fail   = 0;

   pulse_stretcher dut (
      .clk       (clk),
      .rst       (rst),
      .pulse_in  (pulse_in),
      .level_out (level_out),
      .busy      (busy),
      .pending   (pending),
      .overflow  (overflow)
   );

   always #5 clk = ~clk;

   function automatic logic rng(input int n, input int a, input int b);
      return (n >= a) && (n <= b);
   endfunction

   task automatic run_cycle(input string tag, input int c, input logic r, input logic p,
                            input logic el, input logic eb, input logic [1:0] ep,
                            input logic eo);
      exp_t e;
      e.l = el; e.b = eb; e.p = ep; e.o = eo;
      exp_q.push_back(e);
      rst = r;
      pulse_in = p;
      @(posedge clk);
      #1;
      n_assert++;
      assert (exp_q.size() > 0) else begin
         n_fail++;
         $error("FAIL %s scoreboard_empty c=%0d got size 0 expected >0", tag, c);
      end
      if (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         n_assert++;
         assert (level_out === e.l) else begin
            n_fail++;
            $error("FAIL %s level_out c=%0d got %b expected %b", tag, c + 1, level_out, e.l);
         end
         n_assert++;
         assert (busy === e.b) else begin
            n_fail++;
            $error("FAIL %s busy c=%0d got %b expected %b", tag, c + 1, busy, e.b);
         end
         n_assert++;
         assert (pending === e.p) else begin
            n_fail++;
            $error("FAIL %s pending c=%0d got %0d expected %0d", tag, c + 1, pending, e.p);
         end
         n_assert++;
         assert (overflow === e.o) else begin
            n_fail++;
            $error("FAIL %s overflow c=%0d got %b expected %b", tag, c + 1, overflow, e.o);
         end
      end
   endtask

   task automatic do_reset(input string tag);
      for (int i = 0; i < 2; i++) begin
         run_cycle(tag, -1, 1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0);
      end
   endtask

   initial begin
      int n;
      logic [1:0] ep;

      // T1: single event at cycle 10.
      do_reset("t1_rst");
      for (int c = 0; c <= 25; c++) begin
         n = c + 1;
         run_cycle("t1", c, 1'b0, c == 10, rng(n, 11, 14), rng(n, 11, 16), 2'd0, 1'b0);
      end

      // T2: events at cycles 10, 11 and 12 are replayed as three pulses.
      do_reset("t2_rst");
      for (int c = 0; c <= 32; c++) begin
         n = c + 1;
`ifdef PULSE_STRETCHER_EDGE_IN_EN
         run_cycle("t2", c, 1'b0, rng(c, 10, 12), rng(n, 11, 14), rng(n, 11, 16), 2'd0, 1'b0);
`else
         ep = (n == 12) ? 2'd1 : rng(n, 13, 16) ? 2'd2 : rng(n, 17, 22) ? 2'd1 : 2'd0;
         run_cycle("t2", c, 1'b0, rng(c, 10, 12),
                   rng(n, 11, 14) | rng(n, 17, 20) | rng(n, 23, 26),
                   rng(n, 11, 28), ep, 1'b0);
`endif
      end

      // T3: events at cycles 10-15 saturate the pending counter and set overflow.
      do_reset("t3_rst");
      for (int c = 0; c <= 40; c++) begin
         n = c + 1;
`ifdef PULSE_STRETCHER_EDGE_IN_EN
         run_cycle("t3", c, 1'b0, rng(c, 10, 15), rng(n, 11, 14), rng(n, 11, 16), 2'd0, 1'b0);
`else
         ep = (n == 12) ? 2'd1 : (n == 13) ? 2'd2 : rng(n, 14, 16) ? 2'd3 :
              rng(n, 17, 22) ? 2'd2 : rng(n, 23, 28) ? 2'd1 : 2'd0;
         run_cycle("t3", c, 1'b0, rng(c, 10, 15),
                   rng(n, 11, 14) | rng(n, 17, 20) | rng(n, 23, 26) | rng(n, 29, 32),
                   rng(n, 11, 34), ep, n >= 15);
`endif
      end

      // T4: rst at cycle 13 truncates a pulse, and overflow from T3 also clears.
      // This test reuses the state left by T3, so no separate reset precedes it.
      for (int c = 0; c <= 28; c++) begin
         n = c + 1;
         if (c < 13) begin
            run_cycle("t4_pre", c, 1'b0, (c == 10) || (c == 12), rng(n, 11, 13), rng(n, 11, 13),
                      (n >= 13) ? 2'd1 : 2'd0,
`ifdef PULSE_STRETCHER_EDGE_IN_EN
                      1'b0);
`else
                      1'b1);
`endif
         end else begin
            run_cycle("t4", c, c == 13, c == 20, rng(n, 21, 24), rng(n, 21, 26), 2'd0, 1'b0);
         end
      end

      // T5: a new event in the last gap cycle with nothing pending starts directly.
      do_reset("t5_rst");
      for (int c = 0; c <= 26; c++) begin
         n = c + 1;
         run_cycle("t5", c, 1'b0, (c == 10) || (c == 16),
                   rng(n, 11, 14) | rng(n, 17, 20), rng(n, 11, 22), 2'd0, 1'b0);
      end

      // T6: pulse_in is held high for cycles 10-19.
      do_reset("t6_rst");
      for (int c = 0; c <= 45; c++) begin
         n = c + 1;
`ifdef PULSE_STRETCHER_EDGE_IN_EN
         run_cycle("t6", c, 1'b0, rng(c, 10, 19), rng(n, 11, 14), rng(n, 11, 16), 2'd0, 1'b0);
`else
         ep = (n == 12) ? 2'd1 : (n == 13) ? 2'd2 : rng(n, 14, 22) ? 2'd3 :
              rng(n, 23, 28) ? 2'd2 : rng(n, 29, 34) ? 2'd1 : 2'd0;
         run_cycle("t6", c, 1'b0, rng(c, 10, 19),
                   rng(n, 11, 14) | rng(n, 17, 20) | rng(n, 23, 26) |
                   rng(n, 29, 32) | rng(n, 35, 38),
                   rng(n, 11, 40), ep, n >= 15);
`endif
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule

// File: doc/pulse_stretcher.md
Name: pulse_stretcher

Overview:
- Converts single-cycle strobes into level pulses of guaranteed minimum width. It is the inverse of the team's level-to-strobe edge detection.
- Drives LEDs and other slow observers from push/pop/full/empty strobes in the queue/stack design.
- Events that arrive while a pulse is being shown are counted and replayed as separate pulses, each followed by a guaranteed low gap.

Parameters:
HOLD_CYCLES, 4, number of cycles level_out stays high per event (>=1)
GAP_CYCLES, 2, number of forced-low cycles after each high pulse (>=1)
PEND_W, 2, width of the pending-event counter; max pending = 2^PEND_W-1

Ports:
clk  input  1  system clock, all logic on rising edge
rst  input  1  synchronous, active-high reset
pulse_in  input  1  event strobe; each cycle high = one event (see macro)
level_out  output  1  stretched pulse, registered
busy  output  1  high whenever state != IDLE, registered
pending  output  PEND_W  events queued but not yet shown
overflow  output  1  sticky: an event was dropped because pending was saturated

Behaviour:
- Interface: one clock, clk. Reset rst is synchronous and active-high.
- Reset values: level_out=0, busy=0, pending=0, overflow=0, state=IDLE, timer=0.
- rst has priority over all other inputs in any state, including mid-HOLD and mid-GAP. The next cycle shows reset values and the current pulse is truncated.
- States:
  - IDLE: level low.
  - HOLD: level high.
  - GAP: level low.
- Timer: counts down from N-1 to 0. Width is clog2(max(HOLD_CYCLES, GAP_CYCLES)), minimum 1.
- IDLE:
  - If pulse_in is sampled high at edge t: HOLD from t+1 with timer=HOLD_CYCLES-1. pending is unchanged.
  - Latency is 1 cycle from the sampling edge to level_out high.
- HOLD:
  - level_out=1. The timer decrements each cycle.
  - At timer==0: GAP with timer=GAP_CYCLES-1.
  - level_out is high for exactly HOLD_CYCLES cycles.
- GAP:
  - level_out=0. The timer decrements each cycle.
  - At timer==0, if pending>0 or pulse_in: HOLD with timer=HOLD_CYCLES-1. Otherwise go to IDLE.
- Pending accounting (evaluated every non-reset cycle):
  - Enqueue = pulse_in while state is HOLD, or GAP with timer!=0.
  - Dequeue = GAP, timer==0, pending>0.
  - Direct start = pulse_in in IDLE, or pulse_in in the last GAP cycle with pending==0. A direct start does not touch pending.
  - Pulse in the last GAP cycle with pending>0: counts as enqueue and dequeue together, so pending is unchanged.
  - Enqueue and dequeue in the same cycle: pending unchanged.
  - Enqueue only: pending+1, saturating at 2^PEND_W-1.
  - Enqueue at saturation without dequeue: the event is dropped, pending holds, overflow is set to 1.
  - overflow clears only on rst.
- busy = (state != IDLE). It is registered together with the state.
- No combinational path from pulse_in to any output.

Optional Feature:
- Macro: PULSE_STRETCHER_EDGE_IN_EN.
- Defined: an internal register holds pulse_in from the previous cycle. An event is a rising edge only (prev=0, cur=1), so pulse_in may be a level or a button signal. Edge detection adds no extra latency: the event is recognised in the same cycle pulse_in first reads 1. The register resets to 0, so pulse_in already high on the cycle after reset counts as one edge.
- Undefined: every cycle with pulse_in=1 is a separate event.

Test Plan:
- Defaults, rst released; pulse_in high only at cycle 10 -> level_out=1 cycles 11-14, busy=1 cycles 11-16, idle from 17, pending stays 0.
- pulse_in high cycles 10,11,12 -> highs at 11-14, 17-20, 23-26 with lows between; pending is 1 at 12, 2 at 13-16, 1 at 17-22, 0 from 23; overflow stays 0.
- pulse_in high cycles 10-15 (no macro) -> pending saturates at 3 at 14; overflow=1 from 15; exactly 4 high pulses total; overflow stays 1 until rst.
- Two events shown plus one pending; rst asserted at cycle 13 (mid-HOLD) -> from cycle 14 level_out=0, busy=0, pending=0, overflow=0; pulse_in at cycle 20 -> fresh high 21-24.
- Single pulse at cycle 10, second pulse at cycle 16 (last GAP cycle, pending=0) -> second high 17-20 directly, pending never leaves 0.
- pulse_in held high cycles 10-19: with PULSE_STRETCHER_EDGE_IN_EN -> one high 11-14, pending 0. Without the macro -> pending saturates at 3 and overflow=1.
